// File: rtl/cam_arb_pkg.sv
// rtl/cam_arb_pkg.sv - shared types for the two-requester CAM arbiter
package cam_arb_pkg;

    // Requester opcodes; 2'b11 is reserved and answered with an error response.
    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SEARCH = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/cam_arb_sel.sv
// rtl/cam_arb_sel.sv - two-way grant selector
// Ports:
//   req_i   [1:0]  request vector, bit n = requester n
//   ptr_i          requester favoured when both request
//   grant_o [1:0]  one-hot grant (all zero when nothing requests)
module cam_arb_sel (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            // A single request (or none) is already one-hot.
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/cam_arb.sv
// rtl/cam_arb.sv - arbitrates two requesters onto one CAM, one op in flight
// Build option: CAM_ARB_RR_EN selects round-robin between simultaneous
// requests; without it requester 0 always wins.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o [1:0] per-requester command handshake
//   req_op_i/index_i/data_i       packed per-requester command fields
//   rsp_valid_o/rsp_ready_i [1:0] per-requester response handshake
//   rsp_hit/err/data/index_o      shared response payload
//   cam_*_o                       CAM strobes, indices and write/search data
//   cam_*_i                       combinational CAM read/search results
module cam_arb
    import cam_arb_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int WORD_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [3:0]             req_op_i,
    input  logic [2*WORD_BITS-1:0] req_index_i,
    input  logic [2*WORD_SIZE-1:0] req_data_i,
    output logic [1:0]             rsp_valid_o,
    input  logic [1:0]             rsp_ready_i,
    output logic                   rsp_hit_o,
    output logic                   rsp_err_o,
    output logic [WORD_SIZE-1:0]   rsp_data_o,
    output logic [WORD_BITS-1:0]   rsp_index_o,
    output logic                   cam_read_o,
    output logic                   cam_write_o,
    output logic                   cam_search_o,
    output logic [WORD_BITS-1:0]   cam_read_index_o,
    output logic [WORD_BITS-1:0]   cam_write_index_o,
    output logic [WORD_SIZE-1:0]   cam_data_o,
    input  logic                   cam_read_valid_i,
    input  logic [WORD_SIZE-1:0]   cam_read_value_i,
    input  logic                   cam_search_valid_i,
    input  logic [WORD_BITS-1:0]   cam_search_index_i
);

    state_e               state_q;
    logic [1:0]           grant_q;
    op_e                  op_q;
    logic [WORD_BITS-1:0] index_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                 rsp_hit_q;
    logic                 rsp_err_q;
    logic [WORD_SIZE-1:0] rsp_data_q;
    logic [WORD_BITS-1:0] rsp_index_q;

    logic [1:0] sel_grant;
    logic       ptr;
    logic       gidx;

    cam_arb_sel u_sel (
        .req_i   (req_valid_i),
        .ptr_i   (ptr),
        .grant_o (sel_grant)
    );

    assign gidx = sel_grant[1];

`ifdef CAM_ARB_RR_EN
    logic ptr_q;

    // Favour whichever requester did not win the most recent grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (state_q == ST_IDLE && |req_valid_i) begin
            ptr_q <= sel_grant[0];
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            op_q        <= OP_READ;
            index_q     <= '0;
            data_q      <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_index_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        grant_q <= sel_grant;
                        op_q    <= op_e'(gidx ? req_op_i[3:2] : req_op_i[1:0]);
                        index_q <= gidx ? req_index_i[2*WORD_BITS-1:WORD_BITS]
                                        : req_index_i[WORD_BITS-1:0];
                        data_q  <= gidx ? req_data_i[2*WORD_SIZE-1:WORD_SIZE]
                                        : req_data_i[WORD_SIZE-1:0];
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // CAM results are combinational, so they are valid for
                    // the strobe driven during this same cycle.
                    case (op_q)
                        OP_READ: begin
                            rsp_hit_q   <= cam_read_valid_i;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= cam_read_value_i;
                            rsp_index_q <= '0;
                        end
                        OP_WRITE: begin
                            rsp_hit_q   <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= '0;
                            rsp_index_q <= '0;
                        end
                        OP_SEARCH: begin
                            rsp_hit_q   <= cam_search_valid_i;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= '0;
                            rsp_index_q <= cam_search_valid_i ? cam_search_index_i : '0;
                        end
                        default: begin
                            rsp_hit_q   <= 1'b0;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_index_q <= '0;
                        end
                    endcase
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (|(rsp_ready_i & grant_q)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic issue;
    assign issue = (state_q == ST_ISSUE);

    // Ready is the live selector output so the grant and its accept pulse
    // land in the same IDLE cycle.
    assign req_ready_o       = (state_q == ST_IDLE) ? sel_grant : 2'b00;
    assign rsp_valid_o       = (state_q == ST_RESP) ? grant_q : 2'b00;
    assign rsp_hit_o         = rsp_hit_q;
    assign rsp_err_o         = rsp_err_q;
    assign rsp_data_o        = rsp_data_q;
    assign rsp_index_o       = rsp_index_q;

    assign cam_read_o        = issue && (op_q == OP_READ);
    assign cam_write_o       = issue && (op_q == OP_WRITE);
    assign cam_search_o      = issue && (op_q == OP_SEARCH);
    assign cam_read_index_o  = cam_read_o  ? index_q : '0;
    assign cam_write_index_o = cam_write_o ? index_q : '0;
    assign cam_data_o        = (cam_write_o || cam_search_o) ? data_q : '0;

endmodule

// File: tb/tb_cam_arb.sv
// tb/tb_cam_arb.sv - directed self-checking bench for cam_arb with a CAM model
module tb_cam_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid_i = 2'b00;
    logic [1:0]  req_ready_o;
    logic [3:0]  req_op_i = 4'h0;
    logic [9:0]  req_index_i = 10'h0;
    logic [63:0] req_data_i = 64'h0;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i = 2'b00;
    logic        rsp_hit_o;
    logic        rsp_err_o;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_index_o;
    logic        cam_read_o, cam_write_o, cam_search_o;
    logic [4:0]  cam_read_index_o, cam_write_index_o;
    logic [31:0] cam_data_o;
    logic        cam_read_valid_i;
    logic [31:0] cam_read_value_i;
    logic        cam_search_valid_i;
    logic [4:0]  cam_search_index_i;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    cam_arb #(.WORD_SIZE(32), .WORD_BITS(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_op_i           (req_op_i),
        .req_index_i        (req_index_i),
        .req_data_i         (req_data_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_hit_o          (rsp_hit_o),
        .rsp_err_o          (rsp_err_o),
        .rsp_data_o         (rsp_data_o),
        .rsp_index_o        (rsp_index_o),
        .cam_read_o         (cam_read_o),
        .cam_write_o        (cam_write_o),
        .cam_search_o       (cam_search_o),
        .cam_read_index_o   (cam_read_index_o),
        .cam_write_index_o  (cam_write_index_o),
        .cam_data_o         (cam_data_o),
        .cam_read_valid_i   (cam_read_valid_i),
        .cam_read_value_i   (cam_read_value_i),
        .cam_search_valid_i (cam_search_valid_i),
        .cam_search_index_i (cam_search_index_i)
    );

    // CAM model: 32 entries, combinational read/search, lowest matching index wins.
    logic [31:0] mem [32];
    logic [31:0] mem_vld = 32'h0;

    always @(posedge clk) begin
        if (cam_write_o) begin
            mem[cam_write_index_o]     <= cam_data_o;
            mem_vld[cam_write_index_o] <= 1'b1;
        end
    end

    assign cam_read_valid_i = mem_vld[cam_read_index_o];
    assign cam_read_value_i = mem[cam_read_index_o];

    always_comb begin
        cam_search_valid_i = 1'b0;
        cam_search_index_i = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (mem_vld[i] && mem[i] == cam_data_o) begin
                cam_search_valid_i = 1'b1;
                cam_search_index_i = i[4:0];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [4:0] idx,
                           input logic [31:0] d);
        if (r == 0) begin
            req_op_i[1:0]    = op;
            req_index_i[4:0] = idx;
            req_data_i[31:0] = d;
        end else begin
            req_op_i[3:2]     = op;
            req_index_i[9:5]  = idx;
            req_data_i[63:32] = d;
        end
        req_valid_i[r] = 1'b1;
    endtask

    task automatic wait_grant(output logic [1:0] g);
        int n = 0;
        #1;
        while (req_ready_o == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        g = req_ready_o;
    endtask

    task automatic run_op(input int r, input logic [1:0] op, input logic [4:0] idx,
                          input logic [31:0] d, input logic exp_rd, input logic exp_wr,
                          input logic exp_sr, input logic exp_hit, input logic exp_err,
                          input logic [31:0] exp_data, input logic [4:0] exp_idx);
        logic [1:0] g;
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        set_req(r, op, idx, d);
        wait_grant(g);
        check("grant", 64'(g), 64'(oh));
        tick();
        req_valid_i[r] = 1'b0;
        #1;
        check("issue_strobes", 64'({cam_read_o, cam_write_o, cam_search_o}),
              64'({exp_rd, exp_wr, exp_sr}));
        check("issue_ready_low", 64'(req_ready_o), 64'd0);
        if (exp_wr) check("wr_index", 64'(cam_write_index_o), 64'(idx));
        if (exp_rd) check("rd_index", 64'(cam_read_index_o), 64'(idx));
        if (exp_wr || exp_sr) check("cam_data", 64'(cam_data_o), 64'(d));
        tick();
        check("rsp_valid", 64'(rsp_valid_o), 64'(oh));
        check("rsp_hit", 64'(rsp_hit_o), 64'(exp_hit));
        check("rsp_err", 64'(rsp_err_o), 64'(exp_err));
        check("rsp_data", 64'(rsp_data_o), 64'(exp_data));
        check("rsp_index", 64'(rsp_index_o), 64'(exp_idx));
        check("resp_strobes_low", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
        rsp_ready_i = oh;
        tick();
        rsp_ready_i = 2'b00;
        check("rsp_done", 64'(rsp_valid_o), 64'd0);
    endtask

    initial begin
        logic [1:0] g;

        // Reset state
        tick();
        tick();
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
        check("rst_rsp_payload", 64'({rsp_hit_o, rsp_err_o, rsp_data_o, rsp_index_o}), 64'd0);
        rst = 1'b1;
        tick();

        // Write, read back, search hit and miss
        run_op(0, 2'b01, 5'd3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        run_op(1, 2'b00, 5'd3, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 5'd0);
        run_op(0, 2'b10, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd3);
        run_op(0, 2'b10, 5'd0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0);

        // Response back-pressure while requester 1 waits with a reserved opcode
        set_req(0, 2'b00, 5'd3, 32'h0);
        wait_grant(g);
        check("hold_grant", 64'(g), 64'(2'b01));
        tick();
        req_valid_i[0] = 1'b0;
        set_req(1, 2'b11, 5'd7, 32'h55);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 64'(rsp_valid_o), 64'(2'b01));
            check("hold_data", 64'(rsp_data_o), 64'(32'hDEADBEEF));
            check("hold_hit", 64'(rsp_hit_o), 64'd1);
            check("hold_no_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        wait_grant(g);
        check("rsvd_grant", 64'(g), 64'(2'b10));
        tick();
        req_valid_i[1] = 1'b0;
        #1;
        check("rsvd_no_strobe", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
        tick();
        check("rsvd_valid", 64'(rsp_valid_o), 64'(2'b10));
        check("rsvd_err", 64'(rsp_err_o), 64'd1);
        check("rsvd_hit", 64'(rsp_hit_o), 64'd0);
        check("rsvd_payload", 64'({rsp_data_o, rsp_index_o}), 64'd0);
        rsp_ready_i = 2'b10;
        tick();
        rsp_ready_i = 2'b00;

        // Both requesters held valid for four operations
        set_req(0, 2'b00, 5'd3, 32'h0);
        set_req(1, 2'b00, 5'd3, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            check("arb_grant", 64'(g), 64'((RR && k[0]) ? 2'b10 : 2'b01));
            tick();
            tick();
            check("arb_rsp_valid", 64'(rsp_valid_o), 64'(g));
            check("arb_rsp_data", 64'(rsp_data_o), 64'(32'hDEADBEEF));
            rsp_ready_i = 2'b11;
            tick();
            rsp_ready_i = 2'b00;
        end
        req_valid_i = 2'b00;
        tick();

        // Reset asserted during ISSUE
        set_req(0, 2'b01, 5'd5, 32'hCAFE0005);
        wait_grant(g);
        check("rst_op_grant", 64'(g), 64'(2'b01));
        tick();
        req_valid_i = 2'b00;
        check("rst_op_issue", 64'(cam_write_o), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
        check("rst_mid_cam_bus", 64'({cam_write_index_o, cam_data_o}), 64'd0);
        check("rst_mid_handshake", 64'({rsp_valid_o, req_ready_o}), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
            tick();
        end
        check("rst_no_write", 64'(mem_vld[5]), 64'd0);
        set_req(0, 2'b00, 5'd3, 32'h0);
        set_req(1, 2'b00, 5'd3, 32'h0);
        wait_grant(g);
        check("post_rst_grant", 64'(g), 64'(2'b01));
        tick();
        req_valid_i = 2'b00;
        tick();
        check("post_rst_rsp", 64'(rsp_valid_o), 64'(2'b01));
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_arb.md
CAM_ARB -- requirements
Module: cam_arb

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, CAM data width in bits.
REQ-002 SHALL have parameter WORD_BITS, default 5, CAM index width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  2  per-requester command valid; bit n belongs to requester n.
REQ-006 SHALL have port req_ready_o  output  2  per-requester command accept.
REQ-007 SHALL have port req_op_i  input  4  opcode, 2 bits per requester; requester n uses bits [2n+1:2n].
REQ-008 SHALL have port req_index_i  input  2*WORD_BITS  read/write index per requester.
REQ-009 SHALL have port req_data_i  input  2*WORD_SIZE  write/search data per requester.
REQ-010 SHALL have port rsp_valid_o  output  2  per-requester response valid.
REQ-011 SHALL have port rsp_ready_i  input  2  per-requester response accept.
REQ-012 SHALL have port rsp_hit_o  output  1  shared; read_valid or search_valid result; 1 for write.
REQ-013 SHALL have port rsp_err_o  output  1  shared; 1 for reserved opcode.
REQ-014 SHALL have port rsp_data_o  output  WORD_SIZE  shared; read value, else 0.
REQ-015 SHALL have port rsp_index_o  output  WORD_BITS  shared; search index, else 0.
REQ-016 SHALL have ports cam_read_o, cam_write_o, cam_search_o  output  1 each  CAM strobes.
REQ-017 SHALL have ports cam_read_index_o, cam_write_index_o  output  WORD_BITS each  CAM indices.
REQ-018 SHALL have port cam_data_o  output  WORD_SIZE  drives CAM write_data and search_data.
REQ-019 SHALL have ports cam_read_valid_i (1), cam_read_value_i (WORD_SIZE), cam_search_valid_i (1), cam_search_index_i (WORD_BITS)  input  CAM results, combinational off CAM state.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE, one transaction in flight.
REQ-021 SHALL in IDLE, when any req_valid_i bit is set, grant one requester, pulse its req_ready_o for exactly that cycle, latch op/index/data, go to ISSUE.
REQ-022 SHALL in ISSUE drive exactly one CAM strobe for one cycle from latched fields (READ->cam_read_o, WRITE->cam_write_o, SEARCH->cam_search_o); reserved opcode drives none.
REQ-023 SHALL sample CAM results at the end of the ISSUE cycle into response registers and go to RESP.
REQ-024 SHALL in RESP hold rsp_valid_o[grant] high with stable rsp_* until rsp_ready_i[grant]; return to IDLE on the cycle it is accepted.
REQ-025 SHALL keep req_ready_o low outside IDLE; new grants start no earlier than the cycle after response acceptance (minimum 3 cycles per op).
REQ-026 SHALL drive all cam_* outputs 0 outside ISSUE.
REQ-027 SHALL drive rsp_hit_o 0, rsp_err_o 1, data/index 0 for a reserved opcode.
REQ-028 SHALL give rsp_valid_o to the granted requester only; the other bit stays 0.
REQ-029 SHALL allow a requester to drop req_valid_i before grant without effect.

Reset
REQ-030 SHALL on rst low, immediately and regardless of state, go to IDLE, clear all outputs and response registers, and set the round-robin pointer to favour requester 0.
REQ-031 SHALL abandon an in-flight transaction on reset; no response is issued for it.

Configuration
REQ-032 SHALL support macro CAM_ARB_RR_EN: when defined, on simultaneous requests, grant the requester not granted last; when undefined, grant requester 0 over requester 1 (fixed priority).

Structure
REQ-033 SHALL place opcode enum (READ=2'b00, WRITE=2'b01, SEARCH=2'b10, reserved 2'b11) and FSM state typedef in package cam_arb_pkg.
REQ-034 SHALL split grant selection into sub-module cam_arb_sel (2-bit request, pointer in, one-hot grant out).

Verification
REQ-035 SHALL test: req0 WRITE index 3 data 0xDEADBEEF -> one-cycle cam_write_o with index 3, rsp_hit_o=1 to requester 0.
REQ-036 SHALL test: req1 READ index 3 after REQ-035 write -> rsp_data_o=0xDEADBEEF, rsp_hit_o=1 to requester 1.
REQ-037 SHALL test: req0 SEARCH 0xDEADBEEF -> rsp_index_o=3, rsp_hit=1; SEARCH 0x12345678 -> rsp_hit=0, index 0.
REQ-038 SHALL test: both requesters hold valid for 4 ops with CAM_ARB_RR_EN -> grants 0,1,0,1; without -> 0,0,0,0 while req0 stays valid.
REQ-039 SHALL test: rsp_ready_i held low 5 cycles -> rsp_* stable, no new req_ready_o; opcode 2'b11 -> rsp_err_o=1, no CAM strobe.
REQ-040 SHALL test: rst asserted during ISSUE -> outputs 0 in the same cycle, no response after release, next simultaneous request grants requester 0.
